meas_sequencer: RTL
===================

# meas_sequencer

Measurement sequencer for the frequency, period and duty meters. It starts one meter at a time through a req/done handshake and guards each measurement with a timeout. It captures the 16-bit result and assembles the 32-bit word that feeds the eight-digit display. It replaces the free-running `always @(Frequency)` capture in the top level and supports single-shot measurement of one channel or automatic rotation through all three.

## Interface
- `TIMEOUT_CYCLES`, default 100_000_000: max cycles in WAIT before a measurement is abandoned (1 s at 100 MHz).
- `HOLD_CYCLES`, default 50_000_000: display hold time between channels in auto mode (0.5 s).
- `Clk` in 1: 100 MHz board clock. Only clock.
- `Rst` in 1: synchronous, active-high reset.
- `start` in 1: button level, already debounced. Rising edge is detected internally.
- `auto` in 1: 1 = rotate channels 0→1→2→0, 0 = single shot.
- `chan_sel` in 2: manual channel. 0 = frequency, 1 = period, 2 = duty, 3 = invalid.
- `meas_done` in 3: one-hot done pulses from the meters. Bit i belongs to channel i.
- `meas_val0`, `meas_val1`, `meas_val2` in 16 each: meter results, valid in the cycle where the matching `meas_done` is high.
- `meas_req` out 3: one-hot request, held high for the whole measurement.
- `number` out 32: display word.
- `cur_chan` out 2: channel currently or last measured.
- `busy` out 1: high in any state except IDLE.
- `timeout_flag` out 1: high while the displayed value came from a timeout.

## Operation
- States: IDLE, WAIT, HOLD.
- Start edge: `start`=1 with registered `start_d`=0 at the same clock edge.
- IDLE, start edge, manual mode:
  - `chan_sel`<3: latch it into `cur_chan`, set `meas_req[cur_chan]`, clear the timer, go to WAIT.
  - `chan_sel`=3: `number` = 32'hEEEE_EEEE, stay in IDLE.
- IDLE, start edge, `auto`=1: `cur_chan`=0, then as for manual.
- WAIT:
  - Only `meas_done[cur_chan]` is honoured. Done bits of other channels are ignored.
  - On done: `number` = {tag, 12'hFFF, meas_valN}, where tag = `cur_chan`+1. Clear `meas_req` and `timeout_flag`.
  - Timer reaching `TIMEOUT_CYCLES`-1 with no done: `number` = {tag, 12'hFFF, 16'hEEEE}. Set `timeout_flag`, clear `meas_req`.
  - Exit: if `auto` is sampled high at exit and no stop is pending, go to HOLD. Otherwise go to IDLE.
  - Done and timeout in the same cycle: done wins.
- HOLD: count `HOLD_CYCLES`. On expiry, `cur_chan` advances (2 wraps to 0), `meas_req` is set and the state goes to WAIT.
- Start edge while busy:
  - Auto mode: sets `stop_pending`. HOLD goes to IDLE at the next edge. WAIT finishes its measurement and then goes to IDLE. `stop_pending` clears on entering IDLE.
  - Manual mode: ignored.
- `auto` dropping during HOLD: HOLD goes to IDLE at the next edge.
- `Rst` forces these values; any in-progress measurement is abandoned, with no done required:
  - state IDLE
  - `meas_req`=0, `cur_chan`=0, `busy`=0, `timeout_flag`=0, `stop_pending`=0
  - `number`=32'hFFFF_FFFF
  - timer=0, `start_d`=0

## Timing
- All outputs are registered.
- Start edge sampled at edge E: `meas_req` and `busy` are high after E.
- Done sampled at edge D: `number` is updated and `meas_req` is low after D. Capture latency is 1 cycle.
- Timeout: WAIT lasts exactly `TIMEOUT_CYCLES` cycles.
- HOLD lasts exactly `HOLD_CYCLES` cycles.
- Back-to-back done pulses: only the first one in WAIT is captured. Done while not in WAIT is ignored.
- Timer width is $clog2(max(`TIMEOUT_CYCLES`, `HOLD_CYCLES`)). The timer saturates and never wraps.

## Structure
- Package `meas_pkg`:
  - state enum {IDLE, WAIT, HOLD}
  - channel constants CH_FREQ=0, CH_PER=1, CH_DUTY=2
  - BLANK_NIB=4'hF, ERR_WORD=16'hEEEE, RST_NUMBER=32'hFFFF_FFFF
- Sub-module `meas_timer`: clear/enable up-counter with a terminal-count compare against a runtime limit. It is shared by WAIT and HOLD.

## Test plan
Run with `TIMEOUT_CYCLES`=20 and `HOLD_CYCLES`=8.
- Reset: hold `Rst` 2 cycles → `number`=FFFF_FFFF, `meas_req`=000, `busy`=0.
- Manual, `chan_sel`=1, start edge; `meas_done[1]` 5 cycles later with `meas_val1`=16'h0262 → `meas_req`=010 for 5 cycles, then `number`=2FFF_0262, IDLE one cycle after done.
- Manual, `chan_sel`=0, no done → `meas_req` drops after exactly 20 cycles, `number`=1FFF_EEEE, `timeout_flag`=1.
- Auto, meters answer after 3 cycles with values 0x0763, 0x1310, 0x0625 → `number` shows 1FFF_0763, 2FFF_1310, 3FFF_0625 in turn, with an 8-cycle HOLD gap each; then channel 0 is requested again.
- Auto, start edge during HOLD → IDLE next cycle. Start edge during WAIT → capture completes, then IDLE.
- Done on a wrong channel (`meas_done`=100 while `cur_chan`=0) → ignored. `Rst` mid-WAIT → reset values next cycle.

Source files
------------

// File: rtl/meas_pkg.sv
// Shared types and constants for the measurement sequencer.
// Includes the FSM state encoding, channel codes and display-word helpers.
package meas_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    localparam logic [1:0] CH_FREQ = 2'd0;
    localparam logic [1:0] CH_PER  = 2'd1;
    localparam logic [1:0] CH_DUTY = 2'd2;

    localparam logic [3:0]  BLANK_NIB  = 4'hF;
    localparam logic [15:0] ERR_WORD   = 16'hEEEE;
    localparam logic [31:0] RST_NUMBER = 32'hFFFF_FFFF;

    // Display layout: channel tag (1..3), three blank digits, 16-bit value.
    function automatic logic [31:0] disp_word(input logic [1:0] chan, input logic [15:0] val);
        return {{2'b00, chan} + 4'd1, {3{BLANK_NIB}}, val};
    endfunction

    function automatic logic [2:0] chan_onehot(input logic [1:0] chan);
        logic [2:0] oh;
        oh = '0;
        case (chan)
            CH_FREQ: oh = 3'b001;
            CH_PER:  oh = 3'b010;
            CH_DUTY: oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/meas_sequencer_if.sv
// Request/done handshake and result buses between the sequencer and the three meters.
interface meas_sequencer_if;

    logic [2:0]  meas_req;
    logic [2:0]  meas_done;
    logic [15:0] meas_val0;
    logic [15:0] meas_val1;
    logic [15:0] meas_val2;

    modport master (
        output meas_req,
        input  meas_done,
        input  meas_val0,
        input  meas_val1,
        input  meas_val2
    );

    modport slave (
        input  meas_req,
        output meas_done,
        output meas_val0,
        output meas_val1,
        output meas_val2
    );

endinterface

// File: rtl/meas_timer.sv
// Clear/enable saturating up-counter with a terminal-count compare against a runtime limit.
module meas_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge Clk) begin
        if (Rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/meas_sequencer.sv
// Sequences frequency/period/duty measurements with timeout guard and builds the display word.
// Supports single-shot of one channel or automatic rotation with a hold between channels.
module meas_sequencer
    import meas_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
    parameter int unsigned HOLD_CYCLES    = 50_000_000
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    start,
    input  logic                    auto,
    input  logic [1:0]              chan_sel,
    meas_sequencer_if.master        mif,
    output logic [31:0]             number,
    output logic [1:0]              cur_chan,
    output logic                    busy,
    output logic                    timeout_flag
);

    localparam int unsigned MAX_CYC = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
    localparam int unsigned TW      = ($clog2(MAX_CYC) > 0) ? $clog2(MAX_CYC) : 1;
    localparam logic [TW-1:0] TO_LIM   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LIM = TW'(HOLD_CYCLES - 1);

    state_t        state, state_n;
    logic [2:0]    req_n;
    logic [31:0]   number_n;
    logic [1:0]    chan_n;
    logic          tf_n;
    logic          stop_pending, stop_n;
    logic          start_d;
    logic          start_edge;
    logic          done_hit;
    logic          stop_req;
    logic [15:0]   cur_val;
    logic          tmr_clr, tmr_en, tmr_tc;
    logic [TW-1:0] tmr_count, tmr_limit;

    meas_timer #(.WIDTH(TW)) u_timer (
        .Clk    (Clk),
        .Rst    (Rst),
        .clear  (tmr_clr),
        .enable (tmr_en),
        .limit  (tmr_limit),
        .count  (tmr_count),
        .tc     (tmr_tc)
    );

    assign start_edge = start && !start_d;
    assign done_hit   = |(mif.meas_done & chan_onehot(cur_chan));
    // A start edge in the same cycle as the exit counts as a pending stop.
    assign stop_req   = stop_pending || (start_edge && auto);

    always_comb begin
        case (cur_chan)
            CH_FREQ: cur_val = mif.meas_val0;
            CH_PER:  cur_val = mif.meas_val1;
            default: cur_val = mif.meas_val2;
        endcase
    end

    always_comb begin
        state_n   = state;
        req_n     = mif.meas_req;
        number_n  = number;
        chan_n    = cur_chan;
        tf_n      = timeout_flag;
        stop_n    = stop_pending;
        tmr_clr   = 1'b0;
        tmr_en    = 1'b0;
        tmr_limit = (state == HOLD) ? HOLD_LIM : TO_LIM;

        unique case (state)
            IDLE: begin
                if (start_edge) begin
                    if (auto || (chan_sel != 2'd3)) begin
                        chan_n  = auto ? CH_FREQ : chan_sel;
                        req_n   = chan_onehot(chan_n);
                        tmr_clr = 1'b1;
                        state_n = WAIT;
                    end else begin
                        number_n = {2{ERR_WORD}};
                        tf_n     = 1'b0;
                    end
                end
            end
            WAIT: begin
                tmr_en = 1'b1;
                stop_n = stop_req;
                if (done_hit || tmr_tc) begin
                    number_n = disp_word(cur_chan, done_hit ? cur_val : ERR_WORD);
                    tf_n     = !done_hit;
                    req_n    = '0;
                    if (auto && !stop_req) begin
                        tmr_clr = 1'b1;
                        state_n = HOLD;
                    end else begin
                        stop_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            HOLD: begin
                tmr_en = 1'b1;
                if (!auto || stop_pending || start_edge) begin
                    stop_n  = 1'b0;
                    state_n = IDLE;
                end else if (tmr_tc) begin
                    chan_n  = (cur_chan == CH_DUTY) ? CH_FREQ : cur_chan + 2'd1;
                    req_n   = chan_onehot(chan_n);
                    tmr_clr = 1'b1;
                    state_n = WAIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            mif.meas_req <= '0;
            number       <= RST_NUMBER;
            cur_chan     <= CH_FREQ;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
            stop_pending <= 1'b0;
            start_d      <= 1'b0;
        end else begin
            state        <= state_n;
            mif.meas_req <= req_n;
            number       <= number_n;
            cur_chan     <= chan_n;
            busy         <= (state_n != IDLE);
            timeout_flag <= tf_n;
            stop_pending <= stop_n;
            start_d      <= start;
        end
    end

endmodule
